// File: rtl/motor_controller.sv
// Dual-channel PWM / direction driver for an L293-style dual H-bridge.
// Speed commands are shadowed on load and take effect at the next PWM period boundary.
module motor_controller #(
  parameter int PWM_PERIOD = 100,
  parameter int PRESCALE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       motor1_sign,
  input  logic [6:0] motor1_upperlimit,
  input  logic       motor2_sign,
  input  logic [6:0] motor2_upperlimit,
  output logic       enable12,
  output logic       enable34,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       a4,
  output logic       debug_light
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  function automatic logic [CW-1:0] clamp_duty(input logic [6:0] v);
    if (int'(v) > PWM_PERIOD) return CW'(PWM_PERIOD);
    return CW'(v);
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sh_sign_q, sh_sign_d, act_sign_q, act_sign_d;
  logic [CW-1:0] sh_duty_q [2];
  logic [CW-1:0] sh_duty_d [2];
  logic [CW-1:0] act_duty_q [2];
  logic [CW-1:0] act_duty_d [2];
  logic [1:0]    hold_q, hold_d;
  logic          pending_q, pending_d;
  logic [1:0]    en_q, en_d, pa_q, pa_d, pb_q, pb_d;
  logic          dbg_q, dbg_d;
  logic          tick, wrap;

  logic [1:0] sign_in;
  logic [6:0] duty_in [2];
  assign sign_in    = {motor2_sign, motor1_sign};
  assign duty_in[0] = motor1_upperlimit;
  assign duty_in[1] = motor2_upperlimit;

  always_comb begin
    tick       = (pre_q == PRE_LAST);
    wrap       = tick && (cnt_q == CNT_LAST);
    pre_d      = tick ? '0 : pre_q + PW'(1);
    cnt_d      = cnt_q;
    if (tick) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    sh_sign_d  = sh_sign_q;
    act_sign_d = act_sign_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    en_d       = '0;
    pa_d       = '0;
    pb_d       = '0;
    dbg_d      = wrap ? ~dbg_q : dbg_q;
    for (int m = 0; m < 2; m++) begin
      sh_duty_d[m]  = sh_duty_q[m];
      act_duty_d[m] = act_duty_q[m];
    end

    // A load coinciding with a wrap still lands in shadow and re-arms pending.
    if (load) begin
      pending_d = 1'b1;
      for (int m = 0; m < 2; m++) begin
        sh_sign_d[m] = sign_in[m];
        sh_duty_d[m] = clamp_duty(duty_in[m]);
      end
    end else if (wrap) begin
      pending_d = 1'b0;
    end

    for (int m = 0; m < 2; m++) begin
      if (wrap) begin
        hold_d[m] = 1'b0;
        if (pending_q) begin
          hold_d[m]     = (sh_sign_q[m] != act_sign_q[m]) &&
                          (sh_duty_q[m] != '0) && (act_duty_q[m] != '0);
          act_sign_d[m] = sh_sign_q[m];
          act_duty_d[m] = sh_duty_q[m];
        end
      end
      // Outputs are computed from next-state so they line up with the registered count.
      if (!hold_d[m] && act_duty_d[m] != '0) begin
        en_d[m] = (cnt_d < act_duty_d[m]);
        pa_d[m] = act_sign_d[m];
        pb_d[m] = ~act_sign_d[m];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      sh_sign_q  <= '0;
      act_sign_q <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      en_q       <= '0;
      pa_q       <= '0;
      pb_q       <= '0;
      dbg_q      <= 1'b0;
      for (int m = 0; m < 2; m++) begin
        sh_duty_q[m]  <= '0;
        act_duty_q[m] <= '0;
      end
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      sh_sign_q  <= sh_sign_d;
      act_sign_q <= act_sign_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      en_q       <= en_d;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
      dbg_q      <= dbg_d;
      for (int m = 0; m < 2; m++) begin
        sh_duty_q[m]  <= sh_duty_d[m];
        act_duty_q[m] <= act_duty_d[m];
      end
    end
  end

  assign enable12    = en_q[0];
  assign enable34    = en_q[1];
  assign a1          = pa_q[0];
  assign a2          = pb_q[0];
  assign a3          = pa_q[1];
  assign a4          = pb_q[1];
  assign debug_light = dbg_q;

endmodule

// File: tb/tb_motor_controller.sv
// Directed bench for motor_controller: PWM shape, direction, clamp, dead time, reset, heartbeat.
module tb_motor_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       motor1_sign = 1'b0;
  logic [6:0] motor1_upperlimit = '0;
  logic       motor2_sign = 1'b0;
  logic [6:0] motor2_upperlimit = '0;
  logic enable12, enable34, a1, a2, a3, a4, debug_light;
  logic p_en12, p_en34, p_a1, p_a2, p_a3, p_a4, p_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int phase    = 0;

  always #5 clk = ~clk;

  motor_controller dut (
    .clk(clk), .reset(reset), .load(load),
    .motor1_sign(motor1_sign), .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign), .motor2_upperlimit(motor2_upperlimit),
    .enable12(enable12), .enable34(enable34),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .debug_light(debug_light)
  );

  motor_controller #(.PWM_PERIOD(100), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .load(load),
    .motor1_sign(motor1_sign), .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign), .motor2_upperlimit(motor2_upperlimit),
    .enable12(p_en12), .enable34(p_en34),
    .a1(p_a1), .a2(p_a2), .a3(p_a3), .a4(p_a4), .debug_light(p_dbg)
  );

  // Reference PWM position for the PRESCALE=1 instance.
  always @(posedge clk) begin
    if (!reset) phase <= 0;
    else        phase <= (phase == 99) ? 0 : phase + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < 300 && phase != p; k++) @(negedge clk);
  endtask

  task automatic do_load(input logic s1, input int d1, input logic s2, input int d2);
    motor1_sign = s1; motor1_upperlimit = 7'(d1);
    motor2_sign = s2; motor2_upperlimit = 7'(d2);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Observe one full period from count 0 and compare against the expected waveform.
  task automatic check_period(input string tag, input int d1, input logic e1, input logic e2,
                              input int d2, input logic e3, input logic e4);
    int hi1, hi2, enbad1, enbad2, dirbad1, dirbad2;
    hi1 = 0; hi2 = 0; enbad1 = 0; enbad2 = 0; dirbad1 = 0; dirbad2 = 0;
    wait_phase(0);
    for (int i = 0; i < 100; i++) begin
      if (enable12 === 1'b1) hi1++;
      if (enable34 === 1'b1) hi2++;
      if (enable12 !== (i < d1)) enbad1++;
      if (enable34 !== (i < d2)) enbad2++;
      if (a1 !== e1 || a2 !== e2) dirbad1++;
      if (a3 !== e3 || a4 !== e4) dirbad2++;
      @(negedge clk);
    end
    chk({tag, "_hi12"}, hi1, d1);
    chk({tag, "_shape12"}, enbad1, 0);
    chk({tag, "_dir12"}, dirbad1, 0);
    chk({tag, "_hi34"}, hi2, d2);
    chk({tag, "_shape34"}, enbad2, 0);
    chk({tag, "_dir34"}, dirbad2, 0);
  endtask

  initial begin
    int t1a, t1b, t4a, t4b, busy;
    logic prev1, prev4;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, enable12, enable34, a1, a2, a3, a4, debug_light}, 32'd0);
    chk("reset_outputs_ps4", {25'd0, p_en12, p_en34, p_a1, p_a2, p_a3, p_a4, p_dbg}, 32'd0);
    reset = 1'b1;

    check_period("idle", 0, 0, 0, 0, 0, 0);

    wait_phase(10);
    do_load(1'b1, 30, 1'b0, 100);
    check_period("m30_m100", 30, 1, 0, 100, 0, 1);

    wait_phase(40);
    do_load(1'b1, 60, 1'b0, 100);
    wait_phase(50);
    chk("old_duty_persists", {31'd0, enable12}, 32'd0);
    check_period("load_at_40", 60, 1, 0, 100, 0, 1);

    motor1_sign = 1'b0; motor1_upperlimit = 7'd5;
    motor2_upperlimit = 7'd3;
    check_period("noload_a", 60, 1, 0, 100, 0, 1);
    check_period("noload_b", 60, 1, 0, 100, 0, 1);

    wait_phase(10);
    do_load(1'b1, 127, 1'b0, 100);
    check_period("clamp127", 100, 1, 0, 100, 0, 1);

    wait_phase(10);
    do_load(1'b1, 0, 1'b0, 100);
    check_period("duty0_coast", 0, 0, 0, 100, 0, 1);

    wait_phase(10);
    do_load(1'b1, 50, 1'b0, 100);
    check_period("fwd50", 50, 1, 0, 100, 0, 1);

    wait_phase(10);
    do_load(1'b0, 50, 1'b0, 100);
    check_period("deadtime", 0, 0, 0, 100, 0, 1);
    check_period("rev50", 50, 0, 1, 100, 0, 1);

    wait_phase(99);
    do_load(1'b0, 20, 1'b0, 100);
    check_period("wrap_load_old", 50, 0, 1, 100, 0, 1);
    check_period("wrap_load_new", 20, 0, 1, 100, 0, 1);

    wait_phase(50);
    do_load(1'b1, 40, 1'b1, 70);
    wait_phase(60);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {25'd0, enable12, enable34, a1, a2, a3, a4, debug_light}, 32'd0);
    reset = 1'b1;

    t1a = 0; t1b = 0; t4a = 0; t4b = 0; busy = 0;
    prev1 = debug_light; prev4 = p_dbg;
    for (int i = 1; i <= 900; i++) begin
      @(negedge clk);
      if (debug_light !== prev1) begin
        if (t1a == 0) t1a = i; else if (t1b == 0) t1b = i;
      end
      if (p_dbg !== prev4) begin
        if (t4a == 0) t4a = i; else if (t4b == 0) t4b = i;
      end
      prev1 = debug_light; prev4 = p_dbg;
      if ({enable12, enable34, a1, a2, a3, a4} !== 6'b0) busy++;
    end
    chk("post_reset_quiet", busy, 0);
    chk("hb_first", t1a, 100);
    chk("hb_second", t1b, 200);
    chk("hb_ps4_first", t4a, 400);
    chk("hb_ps4_second", t4b, 800);

    wait_phase(10);
    do_load(1'b0, 25, 1'b1, 75);
    check_period("after_reset_load", 25, 0, 1, 75, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
